// File: rtl/spinner_pkg.sv
// Shared types, constants and clamp arithmetic for the multi-channel spinner accumulator.
package spinner_pkg;

    localparam int unsigned DELTA_W     = 8;
    localparam int unsigned SPIN_W      = DELTA_W + 1;
    localparam int unsigned ACCEL_STEPS = 16;
    localparam int unsigned SUM_W       = 32;

    typedef logic signed [DELTA_W-1:0] spin_delta_t;

    typedef struct packed {
        logic        toggle;
        spin_delta_t delta;
    } spin_in_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } dir_e;

    // Saturating add into the range [0, max_v]
    function automatic logic signed [SUM_W-1:0] sat_add(
        input logic signed [SUM_W-1:0] a,
        input logic signed [SUM_W-1:0] b,
        input logic signed [SUM_W-1:0] max_v
    );
        logic signed [SUM_W-1:0] s;
        s = a + b;
        if (s < 0)
            return '0;
        else if (s > max_v)
            return max_v;
        return s;
    endfunction

endpackage

// File: rtl/spinner_chan.sv
// One spinner channel: digital rate divider, analog toggle detect and angle accumulator.
// Optional SPINNER_ACCEL_EN: long same-direction holds switch the channel to the fast rate.
module spinner_chan
    import spinner_pkg::*;
#(
    parameter int unsigned ANGLE_W  = 4,
    parameter int unsigned FRAC_W   = 2,
    parameter int unsigned DIV_SLOW = 8,
    parameter int unsigned DIV_FAST = 2,
    parameter int unsigned CLAMP    = 0,
    parameter int unsigned CENTER   = 0
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stb_p,
    input  logic               minus,
    input  logic               plus,
    input  logic               fast,
    input  spin_in_t           spin_in,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               event_c
);

    localparam int unsigned ACC_W   = ANGLE_W + FRAC_W;
    localparam int unsigned DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int unsigned CNT_W   = $clog2(DIV_MAX + 1);
    localparam int          STEP_I  = 1 << FRAC_W;
    localparam int          ACC_MAX = (1 << ACC_W) - 1;
    localparam logic [ACC_W-1:0] ACC_RST = ACC_W'(ACC_W'(CENTER) << FRAC_W);

    logic [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;
    dir_e                    r_dir;
    logic                    r_tog_valid;
    logic                    r_tog_ref;

    dir_e                    w_dir;
    logic                    w_dir_hold;
    logic                    w_use_fast;
    logic [CNT_W-1:0]        w_limit_m1;
    logic                    w_step;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic signed [SUM_W-1:0] w_step_val;
    logic signed [SUM_W-1:0] w_delta_val;
    logic signed [SUM_W-1:0] w_acc_ext;
    logic signed [SUM_W-1:0] w_sum;

    assign w_dir = (plus ^ minus) ? (plus ? DIR_CW : DIR_CCW) : DIR_IDLE;
    assign w_dir_hold = (w_dir != DIR_IDLE) && (w_dir == r_dir);

`ifdef SPINNER_ACCEL_EN
    localparam int unsigned HOLD_W = $clog2(ACCEL_STEPS + 1);

    logic [HOLD_W-1:0] r_hold;

    // Counts steps of an unbroken hold, saturating at the acceleration threshold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_hold <= '0;
        else if (!w_dir_hold)
            r_hold <= '0;
        else if (w_step && (r_hold != HOLD_W'(ACCEL_STEPS)))
            r_hold <= r_hold + HOLD_W'(1);
    end

    assign w_use_fast = fast || (r_hold == HOLD_W'(ACCEL_STEPS));
`else
    assign w_use_fast = fast;
`endif

    assign event_c = r_tog_valid && (spin_in.toggle != r_tog_ref);

    always_comb begin
        w_limit_m1  = w_use_fast ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);
        w_step      = stb_p && w_dir_hold && (r_cnt >= w_limit_m1);
        w_cnt_nxt   = r_cnt;
        w_step_val  = '0;
        w_delta_val = '0;
        w_acc_ext   = $signed(SUM_W'(r_acc));

        if (!w_dir_hold)
            w_cnt_nxt = '0;
        else if (stb_p)
            w_cnt_nxt = w_step ? '0 : r_cnt + CNT_W'(1);

        if (w_step)
            w_step_val = (w_dir == DIR_CW) ? SUM_W'(STEP_I) : -SUM_W'(STEP_I);
        if (event_c)
            w_delta_val = SUM_W'($signed(spin_in.delta));

        // Wrap mode relies on truncation to ACC_W bits below
        if (CLAMP != 0)
            w_sum = sat_add(w_acc_ext, w_step_val + w_delta_val, SUM_W'(ACC_MAX));
        else
            w_sum = w_acc_ext + w_step_val + w_delta_val;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc       <= ACC_RST;
            r_cnt       <= '0;
            r_dir       <= DIR_IDLE;
            r_tog_valid <= 1'b0;
            r_tog_ref   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_dir       <= w_dir;
            r_tog_valid <= 1'b1;
            r_tog_ref   <= spin_in.toggle;
            if (w_step || event_c)
                r_acc <= w_sum[ACC_W-1:0];
        end
    end

    assign angle_out = r_acc[ACC_W-1:FRAC_W];

endmodule

// File: rtl/spinner_multi.sv
// Multi-channel rotary accumulator: shared strobe edge detect, NCH channels, last-active select.
// Optional SPINNER_ACCEL_EN enables hold acceleration inside each channel.
module spinner_multi
    import spinner_pkg::*;
#(
    parameter int unsigned NCH      = 2,
    parameter int unsigned ANGLE_W  = 4,
    parameter int unsigned FRAC_W   = 2,
    parameter int unsigned DIV_SLOW = 8,
    parameter int unsigned DIV_FAST = 2,
    parameter int unsigned CLAMP    = 0,
    parameter int unsigned CENTER   = 0
)
(
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      strobe,
    input  logic [NCH-1:0]                            minus,
    input  logic [NCH-1:0]                            plus,
    input  logic [NCH-1:0]                            fast,
    input  logic [NCH*SPIN_W-1:0]                     spin_in,
    output logic [NCH*ANGLE_W-1:0]                    angle_out,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  last_sel
);

    localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             r_strobe_d;
    logic [SEL_W-1:0] r_last_sel;
    logic             w_stb_p;
    logic [NCH-1:0]   w_event;
    logic [SEL_W-1:0] w_sel_nxt;

    assign w_stb_p = strobe & ~r_strobe_d;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        spin_in_t w_spin;

        assign w_spin = spin_in[c*SPIN_W +: SPIN_W];

        spinner_chan #(
            .ANGLE_W  (ANGLE_W),
            .FRAC_W   (FRAC_W),
            .DIV_SLOW (DIV_SLOW),
            .DIV_FAST (DIV_FAST),
            .CLAMP    (CLAMP),
            .CENTER   (CENTER)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .stb_p     (w_stb_p),
            .minus     (minus[c]),
            .plus      (plus[c]),
            .fast      (fast[c]),
            .spin_in   (w_spin),
            .angle_out (angle_out[c*ANGLE_W +: ANGLE_W]),
            .event_c   (w_event[c])
        );
    end

    // Later channels overwrite earlier ones, so the highest active index wins
    always_comb begin
        w_sel_nxt = r_last_sel;
        for (int c = 0; c < NCH; c++)
            if (w_event[c])
                w_sel_nxt = SEL_W'(c);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe_d <= 1'b0;
            r_last_sel <= '0;
        end else begin
            r_strobe_d <= strobe;
            r_last_sel <= w_sel_nxt;
        end
    end

    assign last_sel = r_last_sel;

endmodule

// File: tb/tb_spinner_multi.sv
// Directed self-checking bench for spinner_multi (wrap instance plus a clamping instance).
module tb_spinner_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        strobe;
    logic [1:0]  minus, plus, fast;
    logic [17:0] spin_in;
    logic [7:0]  angle_out;
    logic [0:0]  last_sel;
    logic [1:0]  c_minus, c_plus, c_fast;
    logic [17:0] c_spin_in;
    logic [7:0]  c_angle_out;
    logic [0:0]  c_last_sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spinner_multi #(.NCH(2), .CLAMP(0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe    (strobe),
        .minus     (minus),
        .plus      (plus),
        .fast      (fast),
        .spin_in   (spin_in),
        .angle_out (angle_out),
        .last_sel  (last_sel)
    );

    spinner_multi #(.NCH(2), .CLAMP(1)) dut_c (
        .clk       (clk),
        .reset_n   (reset_n),
        .strobe    (strobe),
        .minus     (c_minus),
        .plus      (c_plus),
        .fast      (c_fast),
        .spin_in   (c_spin_in),
        .angle_out (c_angle_out),
        .last_sel  (c_last_sel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            strobe = 1'b1;
            @(negedge clk);
            strobe = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0; strobe = 1'b0;
        minus = '0; plus = '0; fast = '0; spin_in = '0;
        c_minus = '0; c_plus = '0; c_fast = '0; c_spin_in = '0;
        tick(3);
        check("rst_angle", 32'(angle_out), 32'h00);
        check("rst_sel", 32'(last_sel), 32'h0);
        check("rst_c_angle", 32'(c_angle_out), 32'h00);
        reset_n = 1'b1;
        tick(2);

        // slow digital stepping on channel 0
        plus = 2'b01; tick(1);
        strobes(7);  check("slow_7", 32'(angle_out[3:0]), 32'h0);
        strobes(1);  check("slow_8", 32'(angle_out[3:0]), 32'h1);
        strobes(8);  check("slow_16", 32'(angle_out[3:0]), 32'h2);
        check("slow_ch1", 32'(angle_out[7:4]), 32'h0);
        plus = 2'b00; tick(1);

        // fast stepping with wrap through 4'hF
        fast = 2'b01; plus = 2'b01; tick(1);
        strobes(2);  check("fast_2", 32'(angle_out[3:0]), 32'h3);
        strobes(24); check("fast_F", 32'(angle_out[3:0]), 32'hF);
        strobes(2);  check("fast_wrap", 32'(angle_out[3:0]), 32'h0);
        strobes(4);  check("fast_32", 32'(angle_out[3:0]), 32'h2);
        plus = 2'b00; tick(1);

        // rate switch mid-count steps at once when count already past new limit
        plus = 2'b01; fast = 2'b00; tick(1);
        strobes(5);  check("midcnt_slow", 32'(angle_out[3:0]), 32'h2);
        fast = 2'b01;
        strobes(1);  check("midcnt_fast", 32'(angle_out[3:0]), 32'h3);

        // direction change mid-count restarts the divider
        plus = 2'b00; fast = 2'b00; minus = 2'b01; tick(1);
        strobes(4);
        minus = 2'b00; plus = 2'b01; tick(1);
        strobes(7);  check("dirchg_7", 32'(angle_out[3:0]), 32'h3);
        strobes(1);  check("dirchg_8", 32'(angle_out[3:0]), 32'h4);
        plus = 2'b00; tick(1);
        minus = 2'b01; tick(1);
        strobes(8);  check("minus_8", 32'(angle_out[3:0]), 32'h3);

        // both held is idle
        plus = 2'b01; minus = 2'b01; tick(1);
        strobes(40); check("both_held", 32'(angle_out[3:0]), 32'h3);
        plus = 2'b00; minus = 2'b00; tick(1);

        // analog deltas and last_sel priority
        spin_in[17:9] = {1'b1, 8'h08}; tick(1);
        check("an_ch1_up", 32'(angle_out[7:4]), 32'h2);
        check("an_sel1", 32'(last_sel), 32'h1);
        spin_in[17:9] = {1'b0, 8'hF8}; tick(1);
        check("an_ch1_back", 32'(angle_out[7:4]), 32'h0);
        check("an_sel1b", 32'(last_sel), 32'h1);
        spin_in[8:0] = {1'b1, 8'h04}; tick(1);
        check("an_ch0", 32'(angle_out[3:0]), 32'h4);
        check("an_sel0", 32'(last_sel), 32'h0);
        spin_in[8:0] = {1'b0, 8'h04}; spin_in[17:9] = {1'b1, 8'h04}; tick(1);
        check("an_both_ch0", 32'(angle_out[3:0]), 32'h5);
        check("an_both_ch1", 32'(angle_out[7:4]), 32'h1);
        check("an_both_sel", 32'(last_sel), 32'h1);
        spin_in[17:9] = {1'b0, 8'hF0}; tick(1);
        check("an_neg_wrap", 32'(angle_out[7:4]), 32'hD);

        // digital step and analog delta in the same cycle, fraction retained
        plus = 2'b01; fast = 2'b01; tick(1);
        strobes(1);  check("comb_pre", 32'(angle_out[3:0]), 32'h5);
        strobe = 1'b1; spin_in[8:0] = {1'b1, 8'h02}; tick(1);
        strobe = 1'b0;
        check("comb_sum", 32'(angle_out[3:0]), 32'h6);
        spin_in[8:0] = {1'b0, 8'h02}; tick(1);
        check("frac_carry", 32'(angle_out[3:0]), 32'h7);
        check("comb_sel", 32'(last_sel), 32'h0);
        plus = 2'b00; fast = 2'b00; tick(1);

        // asynchronous reset mid-count, toggle reference recaptured afterwards
        plus = 2'b01; tick(1);
        strobes(3);
        reset_n = 1'b0; #1;
        check("async_ch0", 32'(angle_out[3:0]), 32'h0);
        check("async_ch1", 32'(angle_out[7:4]), 32'h0);
        check("async_sel", 32'(last_sel), 32'h0);
        spin_in[8:0] = {1'b1, 8'h10}; spin_in[17:9] = {1'b1, 8'h20}; plus = 2'b00;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("ref_ch0", 32'(angle_out[3:0]), 32'h0);
        check("ref_ch1", 32'(angle_out[7:4]), 32'h0);
        plus = 2'b01; tick(1);
        strobes(5);  check("cnt_cleared", 32'(angle_out[3:0]), 32'h0);
        strobes(3);  check("cnt_after_rst", 32'(angle_out[3:0]), 32'h1);
        plus = 2'b00; tick(1);

        // clamping instance
        c_minus = 2'b01; tick(1);
        strobes(64); check("clamp_low", 32'(c_angle_out[3:0]), 32'h0);
        c_spin_in[8:0] = {1'b1, 8'h80}; tick(1);
        check("clamp_low_an", 32'(c_angle_out[3:0]), 32'h0);
        c_minus = 2'b00;
        c_spin_in[8:0] = {1'b0, 8'h7F}; tick(1);
        check("clamp_high_an", 32'(c_angle_out[3:0]), 32'hF);
        c_plus = 2'b01; c_fast = 2'b01; tick(1);
        strobes(4);  check("clamp_high", 32'(c_angle_out[3:0]), 32'hF);
        c_plus = 2'b00; c_minus = 2'b01; tick(1);
        strobes(2);  check("clamp_exact_max", 32'(c_angle_out[3:0]), 32'hE);
        check("clamp_ch1", 32'(c_angle_out[7:4]), 32'h0);
        check("clamp_sel", 32'(c_last_sel), 32'h0);
        c_minus = 2'b00; tick(1);

`ifdef SPINNER_ACCEL_EN
        // hold acceleration after 16 slow steps
        fast = 2'b00; plus = 2'b01; tick(1);
        strobes(127); check("accel_15", 32'(angle_out[3:0]), 32'h0);
        strobes(1);   check("accel_16", 32'(angle_out[3:0]), 32'h1);
        strobes(1);   check("accel_fast_a", 32'(angle_out[3:0]), 32'h1);
        strobes(1);   check("accel_fast_b", 32'(angle_out[3:0]), 32'h2);
        plus = 2'b00; tick(1);
        plus = 2'b01; tick(1);
        strobes(2);   check("accel_clr_a", 32'(angle_out[3:0]), 32'h2);
        strobes(6);   check("accel_clr_b", 32'(angle_out[3:0]), 32'h3);
        plus = 2'b00; tick(1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
